// File: rtl/chip_io_pkg.sv
// Shared widths, configuration field positions and FSM states
// for the chip IO return path.
package chip_io_pkg;

    localparam int NORTH_W = 10;
    localparam int EDGE_W = 14;
    localparam int N_MACROS = 4;
    localparam int CFG_W = 4;

    localparam int WEST_SEL = 0;
    localparam int EAST_SEL = 1;
    localparam int NORTH_SEL_LO = 2;
    localparam int NORTH_SEL_HI = 3;

    typedef enum logic {
        QUIET,
        ACTIVE
    } state_t;

    typedef logic [N_MACROS-1:0][NORTH_W-1:0] north_bus_t;
    typedef logic [N_MACROS-1:0][EDGE_W-1:0] edge_bus_t;

endpackage

// File: rtl/chip_input_distributor_pad_sync.sv
// Multi-flop synchroniser for asynchronous pad and
// configuration inputs.
module pad_sync #(
    parameter int W = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [SYNC_STAGES-1:0][W-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/chip_input_distributor.sv
// Routes synchronised pad banks to macro inputs, with a quiet
// window of forced zeros around every configuration change.
module chip_input_distributor
    import chip_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int QUIET_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NORTH_W-1:0]  IO_north_i,
    input  logic [EDGE_W-1:0]   IO_west_i,
    input  logic [EDGE_W-1:0]   IO_east_i,
    input  logic [CFG_W-1:0]    configuration,
    output north_bus_t          north_i,
    output edge_bus_t           west_i,
    output edge_bus_t           east_i,
    output logic [CFG_W-1:0]    active_cfg,
    output logic                busy,
    output logic                cfg_applied
);

    localparam logic [7:0] QLOAD = 8'(QUIET_CYCLES);

    logic [NORTH_W-1:0] n_s;
    logic [EDGE_W-1:0]  w_s;
    logic [EDGE_W-1:0]  e_s;
    logic [CFG_W-1:0]   cfg_s;

    pad_sync #(.W(NORTH_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_n (
        .clk(clk), .rst(rst), .d(IO_north_i), .q(n_s)
    );
    pad_sync #(.W(EDGE_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_w (
        .clk(clk), .rst(rst), .d(IO_west_i), .q(w_s)
    );
    pad_sync #(.W(EDGE_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_e (
        .clk(clk), .rst(rst), .d(IO_east_i), .q(e_s)
    );
    pad_sync #(.W(CFG_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_c (
        .clk(clk), .rst(rst), .d(configuration), .q(cfg_s)
    );

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [CFG_W-1:0]  cap_cfg, cap_nxt;
    logic [CFG_W-1:0]  act_nxt;
    logic              applied_nxt;
    north_bus_t        n_nxt;
    edge_bus_t         w_nxt;
    edge_bus_t         e_nxt;
    logic [1:0]        n_own;
    logic [1:0]        w_own;
    logic [1:0]        e_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= QUIET;
            cnt         <= QLOAD;
            cap_cfg     <= '0;
            active_cfg  <= '0;
            cfg_applied <= 1'b0;
            north_i     <= '0;
            west_i      <= '0;
            east_i      <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cap_cfg     <= cap_nxt;
            active_cfg  <= act_nxt;
            cfg_applied <= applied_nxt;
            north_i     <= n_nxt;
            west_i      <= w_nxt;
            east_i      <= e_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cap_nxt     = cap_cfg;
        act_nxt     = active_cfg;
        applied_nxt = 1'b0;
        case (state)
            QUIET: begin
                if (cfg_s != cap_cfg) begin
                    cap_nxt = cfg_s;
                    cnt_nxt = QLOAD;
                end else if (cnt == 8'd0) begin
                    act_nxt     = cap_cfg;
                    applied_nxt = 1'b1;
                    state_nxt   = ACTIVE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ACTIVE: begin
                if (cfg_s != active_cfg) begin
                    cap_nxt   = cfg_s;
                    cnt_nxt   = QLOAD;
                    state_nxt = QUIET;
                end
            end
            default: state_nxt = QUIET;
        endcase
    end

    // Routing uses the next-cycle mapping so the output register
    // never shows a mix of old and new owners.
    always_comb begin
        n_own = act_nxt[NORTH_SEL_HI:NORTH_SEL_LO];
        w_own = {act_nxt[WEST_SEL], 1'b0};
        e_own = {act_nxt[EAST_SEL], 1'b1};
        n_nxt = '0;
        w_nxt = '0;
        e_nxt = '0;
        if (state_nxt == ACTIVE) begin
            n_nxt[n_own] = n_s;
            w_nxt[w_own] = w_s;
            e_nxt[e_own] = e_s;
        end
    end

    assign busy = (state == QUIET);

endmodule

// File: tb/tb_chip_input_distributor.sv
// Directed bench: reset/quiet timing, reconfiguration corners
// and a table walk over routing configurations.
module tb_chip_input_distributor;
    import chip_io_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [NORTH_W-1:0] IO_north_i;
    logic [EDGE_W-1:0]  IO_west_i;
    logic [EDGE_W-1:0]  IO_east_i;
    logic [CFG_W-1:0]   configuration;
    north_bus_t         north_i;
    edge_bus_t          west_i;
    edge_bus_t          east_i;
    logic [CFG_W-1:0]   active_cfg;
    logic               busy;
    logic               cfg_applied;

    chip_input_distributor #(.SYNC_STAGES(2), .QUIET_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .IO_north_i(IO_north_i),
        .IO_west_i(IO_west_i),
        .IO_east_i(IO_east_i),
        .configuration(configuration),
        .north_i(north_i),
        .west_i(west_i),
        .east_i(east_i),
        .active_cfg(active_cfg),
        .busy(busy),
        .cfg_applied(cfg_applied)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  cfg;
        logic [9:0]  n;
        logic [13:0] w;
        logic [13:0] e;
        logic [1:0]  on;
        logic [1:0]  ow;
        logic [1:0]  oe;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic north_bus_t mk_n(input logic [1:0] own,
                                        input logic [9:0] v);
        north_bus_t r;
        r = '0;
        r[own] = v;
        return r;
    endfunction

    function automatic edge_bus_t mk_e(input logic [1:0] own,
                                       input logic [13:0] v);
        edge_bus_t r;
        r = '0;
        r[own] = v;
        return r;
    endfunction

    // Returns the cycle index of the first pulse, 0 on timeout.
    task automatic wait_pulse(input int lim, output int k);
        k = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (cfg_applied) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int first;
        int pulses;
        logic saw_busy;

        tbl = '{
            '{4'b0000, 10'h001, 14'h0001, 14'h2000, 2'd0, 2'd0, 2'd1},
            '{4'b0100, 10'h155, 14'h3FFF, 14'h1234, 2'd1, 2'd0, 2'd1},
            '{4'b1000, 10'h2AA, 14'h0F0F, 14'h3C3C, 2'd2, 2'd0, 2'd1},
            '{4'b1100, 10'h3FF, 14'h1111, 14'h2222, 2'd3, 2'd0, 2'd1},
            '{4'b1101, 10'h0F0, 14'h2468, 14'h1357, 2'd3, 2'd2, 2'd1},
            '{4'b1010, 10'h00F, 14'h0ABC, 14'h3DEF, 2'd2, 2'd0, 2'd3},
            '{4'b0111, 10'h300, 14'h3000, 14'h0003, 2'd1, 2'd2, 2'd3}
        };

        rst = 1'b1;
        configuration = 4'h0;
        IO_north_i = '0;
        IO_west_i = '0;
        IO_east_i = '0;
        cyc(2);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_applied", 64'(cfg_applied), 64'd0);
        chk("rst_active_cfg", 64'(active_cfg), 64'd0);
        chk("rst_west", 64'(west_i), 64'd0);

        // Release: quiet for 8 cycles, active and pulse on the 9th.
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("boot_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        chk("boot_busy_end", 64'(busy), 64'd0);
        chk("boot_pulse", 64'(cfg_applied), 64'd1);
        chk("boot_active_cfg", 64'(active_cfg), 64'd0);
        @(negedge clk);
        chk("boot_pulse_one", 64'(cfg_applied), 64'd0);

        // Pad latency is SYNC_STAGES + 1 = 3 cycles.
        IO_west_i = 14'h1ABC;
        cyc(2);
        chk("lat_west_early", 64'(west_i), 64'd0);
        cyc(1);
        chk("lat_west", 64'(west_i), 64'(mk_e(2'd0, 14'h1ABC)));

        // Reconfigure to 4'b1111 while active.
        IO_north_i = 10'h2AA;
        IO_east_i = 14'h0F0F;
        cyc(4);
        configuration = 4'hF;
        cyc(2);
        chk("f_busy_early", 64'(busy), 64'd0);
        cyc(1);
        chk("f_busy", 64'(busy), 64'd1);
        chk("f_north0", 64'(north_i), 64'd0);
        chk("f_west0", 64'(west_i), 64'd0);
        chk("f_east0", 64'(east_i), 64'd0);
        wait_pulse(40, k);
        chk("f_pulse_cycle", 64'(k), 64'd9);
        chk("f_active_cfg", 64'(active_cfg), 64'hF);
        chk("f_north", 64'(north_i), 64'(mk_n(2'd3, 10'h2AA)));
        chk("f_west", 64'(west_i), 64'(mk_e(2'd2, 14'h1ABC)));
        chk("f_east", 64'(east_i), 64'(mk_e(2'd3, 14'h0F0F)));

        // Two changes 3 cycles apart: only the last one applies.
        cyc(1);
        configuration = 4'h5;
        cyc(3);
        chk("tog_busy", 64'(busy), 64'd1);
        configuration = 4'h6;
        first = 0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cfg_applied) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("tog_pulse_cycle", 64'(first), 64'd12);
        chk("tog_pulses", 64'(pulses), 64'd1);
        chk("tog_active_cfg", 64'(active_cfg), 64'h6);
        chk("tog_north", 64'(north_i), 64'(mk_n(2'd1, 10'h2AA)));
        chk("tog_west", 64'(west_i), 64'(mk_e(2'd0, 14'h1ABC)));
        chk("tog_east", 64'(east_i), 64'(mk_e(2'd3, 14'h0F0F)));

        // Same value rewritten with new data: no quiet, no pulse.
        configuration = 4'h6;
        IO_west_i = 14'h0555;
        saw_busy = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (cfg_applied) pulses++;
        end
        chk("same_busy", 64'(saw_busy), 64'd0);
        chk("same_pulses", 64'(pulses), 64'd0);
        chk("same_west", 64'(west_i), 64'(mk_e(2'd0, 14'h0555)));

        // Async reset mid-active.
        IO_north_i = 10'h3FF;
        cyc(4);
        chk("pre_rst_north", 64'(north_i), 64'(mk_n(2'd1, 10'h3FF)));
        #2 rst = 1'b1;
        #1;
        chk("arst_north", 64'(north_i), 64'd0);
        chk("arst_busy", 64'(busy), 64'd1);
        chk("arst_active_cfg", 64'(active_cfg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        // Sync chain restarts at 0, so 4'h6 is seen 3 cycles in.
        wait_pulse(40, k);
        chk("rerun_pulse_cycle", 64'(k), 64'd12);
        chk("rerun_active_cfg", 64'(active_cfg), 64'h6);
        chk("rerun_north", 64'(north_i), 64'(mk_n(2'd1, 10'h3FF)));

        // Table walk over owner selections.
        foreach (tbl[i]) begin
            @(negedge clk);
            configuration = tbl[i].cfg;
            IO_north_i = tbl[i].n;
            IO_west_i = tbl[i].w;
            IO_east_i = tbl[i].e;
            wait_pulse(40, k);
            chk($sformatf("tbl%0d_pulse", i), 64'(k), 64'd12);
            chk($sformatf("tbl%0d_cfg", i), 64'(active_cfg),
                64'(tbl[i].cfg));
            chk($sformatf("tbl%0d_north", i), 64'(north_i),
                64'(mk_n(tbl[i].on, tbl[i].n)));
            chk($sformatf("tbl%0d_west", i), 64'(west_i),
                64'(mk_e(tbl[i].ow, tbl[i].w)));
            chk($sformatf("tbl%0d_east", i), 64'(east_i),
                64'(mk_e(tbl[i].oe, tbl[i].e)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/chip_input_distributor.md
Name: chip_input_distributor

Overview:
- Return path of the 2x2 multi-macro chip's IO routing: takes synchronised pad inputs from the north, west and east IO banks and delivers them to the inputs of the four macros, selected by `configuration`.
- The output-side divider drives pads from macros; this block drives macros from pads.
- Adds safe reconfiguration: on a `configuration` change, all macro inputs are held at 0 for a quiet window before the new mapping applies.

Parameters:
- SYNC_STAGES, 2, flop stages in each pad/configuration synchroniser (legal 2..4).
- QUIET_CYCLES, 8, cycles macro inputs are forced to 0 before a new configuration is applied (legal 1..255).

Ports:
- clk  input  1  block clock
- rst  input  1  asynchronous, active-high reset
- IO_north_i  input  10  north pad inputs (asynchronous)
- IO_west_i  input  14  west pad inputs (asynchronous)
- IO_east_i  input  14  east pad inputs (asynchronous)
- configuration  input  4  requested routing (asynchronous, quasi-static)
- north_i  output  [3:0] x 10  per-macro north inputs
- west_i  output  [3:0] x 14  per-macro west inputs
- east_i  output  [3:0] x 14  per-macro east inputs
- active_cfg  output  4  configuration currently applied
- busy  output  1  high while in QUIET (all macro inputs forced 0)
- cfg_applied  output  1  one-cycle pulse when a configuration is applied

Behaviour:
- Macro layout:
  - Column 0 holds macros 0 and 2; column 1 holds macros 1 and 3.
  - Macros 0 and 1 are the top row.
- Decode of `active_cfg`:
  - Bit 0: west bank owner; 0 means macro 0, 1 means macro 2.
  - Bit 1: east bank owner; 0 means macro 1, 1 means macro 3.
  - Bits 3:2: north bank owner, as a macro index 0..3.
- Routing:
  - The owner macro's port receives the synchronised bank value.
  - Every non-owner port is 0.
  - Unused edges (east edge of column 0, west edge of column 1) are always 0.
- Synchronisers: all pad inputs and `configuration` pass through SYNC_STAGES flops.
- Data latency: pad change to macro output = SYNC_STAGES + 1 cycles (output registered), while in ACTIVE.
- FSM states:
  - QUIET: counter decrements each cycle. `busy` = 1. All macro outputs 0.
    - If the synchronised `configuration` differs from the value captured on QUIET entry, capture the new value and reload the counter with QUIET_CYCLES.
    - When the counter reaches 0: `active_cfg` <= captured value, `cfg_applied` = 1 for one cycle, go to ACTIVE.
  - ACTIVE: routing per `active_cfg`. `busy` = 0.
    - If the synchronised `configuration` differs from `active_cfg`: capture it, load the counter, go to QUIET. Outputs are 0 from the next cycle.
- Reset (async assert; release is synchronous through the flops):
  - State QUIET, counter = QUIET_CYCLES.
  - `active_cfg` = 0, captured configuration = 0.
  - All macro outputs 0, `busy` = 1, `cfg_applied` = 0, synchroniser flops 0.
- Timing after release with stable configuration: first ACTIVE cycle is QUIET_CYCLES + 1 cycles after reset deassertion.
- Reset mid-QUIET or mid-ACTIVE: immediate return to the reset values. No partial-mapping glitch.
- Same configuration rewritten: no QUIET entry, no pulse.
- Configuration toggling faster than QUIET_CYCLES: the block stays in QUIET indefinitely; only the last stable value is applied.
- Counter width: 8 bits, no wrap (saturates at 0 on exit).

Decomposition:
- Package chip_io_pkg:
  - NORTH_W = 10, EDGE_W = 14, N_MACROS = 4.
  - Configuration field positions (WEST_SEL = 0, EAST_SEL = 1, NORTH_SEL = 3:2).
  - State enum {QUIET, ACTIVE}.
- Sub-module pad_sync: parameterised width and SYNC_STAGES, async-reset flop chain. Instantiated for the three banks and for `configuration`.

Test Plan:
- Reset with configuration = 4'b0000, hold stable -> `busy` = 1 for 8 cycles after sync, then `cfg_applied` pulse and `active_cfg` = 0. IO_west_i = 14'h1ABC appears on west_i[0] 3 cycles later; west_i[2] = 0.
- In ACTIVE, configuration -> 4'b1111 -> all outputs 0 within SYNC_STAGES + 1 cycles for 8 cycles, then west_i[2], east_i[3], north_i[3] carry pad values; all other ports 0.
- During QUIET, change configuration twice, 3 cycles apart -> counter restarts each time. Only the final value is applied, with exactly one `cfg_applied` pulse.
- Configuration rewritten with the same value in ACTIVE -> `busy` stays 0, no pulse, data uninterrupted.
- Assert rst mid-ACTIVE with IO_north_i = 10'h3FF -> all macro outputs 0 and `busy` = 1 in the same cycle (async), and the full quiet sequence repeats after release.
- Walk NORTH_SEL 0..3 -> only north_i[sel] is non-zero; east_i[0], east_i[2], west_i[1] and west_i[3] remain 0 throughout.
